axi_reg_arbiter: RTL and testbench

Two-requester round-robin arbiter and AXI master sequencer sitting in front of the 8-word AXI register slave. It accepts single-word read/write commands from two internal requesters over a simple req/done interface, grants one at a time, drives one complete AXI single-beat transaction (AW+W→B or AR→R) to the slave, and returns read data and completion status to the granted requester.

---
 rtl/axi_reg_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi_reg_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_arbiter.sv
// Two-requester round-robin arbiter driving single-beat AXI transactions to the register slave.
// Optional slave-handshake timeout abort is compiled in with `define AXI_ARB_TIMEOUT_EN.
module axi_reg_arbiter #(
    parameter int TIMEOUT_CYC = 16,
    parameter int NREQ        = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ*32-1:0]   addr_i,
    input  logic [NREQ*32-1:0]   wdata_i,
    input  logic [NREQ*4-1:0]    wstrb_i,
    output logic [NREQ-1:0]      done_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [3:0]           awid_o,
    output logic [3:0]           arid_o,
    output logic [31:0]          awaddr_o,
    output logic                 awvalid_o,
    input  logic                 awready_i,
    output logic [31:0]          wdata_o,
    output logic [3:0]           wstrb_o,
    output logic                 wvalid_o,
    input  logic                 wready_i,
    input  logic [1:0]           bresp_i,
    input  logic                 bvalid_i,
    output logic                 bready_o,
    output logic [31:0]          araddr_o,
    output logic                 arvalid_o,
    input  logic                 arready_i,
    input  logic [31:0]          rdata_i,
    input  logic                 rvalid_i,
    output logic                 rready_o
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state, state_next;
    logic        gnt_idx, last_served, grant_sel;
    logic [31:0] cmd_addr, cmd_wdata, rdata_r;
    logic [3:0]  cmd_wstrb;
    logic        aw_done, w_done, err_r;
    logic        tmo_expire, tmo_abort;

    // Requester other than the last served wins a tie; a lone requester wins outright.
    always_comb begin
        grant_sel = req_i[1];
        if (req_i == 2'b11) grant_sel = ~last_served;
    end

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;

    assign waiting    = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
    assign tmo_expire = waiting && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset)                              tmo_cnt <= '0;
        else if (state_next != state || !waiting) tmo_cnt <= '0;
        else                                     tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
`else
    assign tmo_expire = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tmo_abort  = 1'b0;
        awvalid_o  = 1'b0;
        wvalid_o   = 1'b0;
        bready_o   = 1'b0;
        arvalid_o  = 1'b0;
        rready_o   = 1'b0;
        done_o     = '0;
        rdata_o    = '0;
        err_o      = 1'b0;
        case (state)
            IDLE: begin
                if (|req_i) state_next = we_i[grant_sel] ? WADDR : RADDR;
            end
            WADDR: begin
                awvalid_o = ~aw_done;
                wvalid_o  = ~w_done;
                if ((aw_done || awready_i) && (w_done || wready_i)) state_next = WRESP;
            end
            WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) state_next = DONE;
            end
            RADDR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_next = RDATA;
            end
            RDATA: begin
                rready_o = 1'b1;
                if (rvalid_i) state_next = DONE;
            end
            DONE: begin
                done_o[gnt_idx] = 1'b1;
                rdata_o         = rdata_r;
                err_o           = err_r;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort only when the wait would otherwise continue; a handshake on the last cycle still completes.
        if (tmo_expire && state_next == state) begin
            tmo_abort  = 1'b1;
            state_next = DONE;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            gnt_idx     <= 1'b0;
            last_served <= 1'b1;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_wstrb   <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_idx     <= grant_sel;
                        last_served <= grant_sel;
                        cmd_addr    <= grant_sel ? addr_i[63:32]  : addr_i[31:0];
                        cmd_wdata   <= grant_sel ? wdata_i[63:32] : wdata_i[31:0];
                        cmd_wstrb   <= grant_sel ? wstrb_i[7:4]   : wstrb_i[3:0];
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        err_r       <= 1'b0;
                        rdata_r     <= '0;
                    end
                end
                WADDR: begin
                    if (awvalid_o && awready_i) aw_done <= 1'b1;
                    if (wvalid_o && wready_i)   w_done  <= 1'b1;
                end
                WRESP: begin
                    if (bvalid_i) err_r <= (bresp_i != 2'b00);
                end
                RDATA: begin
                    if (rvalid_i) begin
                        rdata_r <= rdata_i;
                        err_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (tmo_abort) begin
                err_r   <= 1'b1;
                rdata_r <= '0;
            end
        end
    end

    assign awaddr_o = cmd_addr;
    assign araddr_o = cmd_addr;
    assign wdata_o  = cmd_wdata;
    assign wstrb_o  = cmd_wstrb;
    assign awid_o   = {3'b000, gnt_idx};
    assign arid_o   = {3'b000, gnt_idx};

endmodule

// File: tb/tb_axi_reg_arbiter.sv
// Directed self-checking bench for axi_reg_arbiter with a small behavioural 8-word AXI slave.
// Timeout scenario runs only when AXI_ARB_TIMEOUT_EN is defined.
module tb_axi_reg_arbiter;

    logic        clk, areset;
    logic [1:0]  req_i, we_i;
    logic [63:0] addr_i, wdata_i;
    logic [7:0]  wstrb_i;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [3:0]  awid_o, arid_o;
    logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, awready_i, wvalid_o, wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;

    int checks = 0;
    int errors = 0;

    logic        b_hold;
    logic        aw_seen, w_seen, ar_seen;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [8];

    axi_reg_arbiter #(.TIMEOUT_CYC(16), .NREQ(2)) dut (
        .clk(clk), .areset(areset),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .awid_o(awid_o), .arid_o(arid_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: B/R valid is raised the cycle after both address/data handshakes are seen.
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            aw_seen  <= 1'b0;
            w_seen   <= 1'b0;
            ar_seen  <= 1'b0;
            bvalid_i <= 1'b0;
            rvalid_i <= 1'b0;
            rdata_i  <= '0;
            s_awaddr <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            s_araddr <= '0;
        end else begin
            if (awvalid_o && awready_i) begin
                aw_seen  <= 1'b1;
                s_awaddr <= awaddr_o;
            end
            if (wvalid_o && wready_i) begin
                w_seen  <= 1'b1;
                s_wdata <= wdata_o;
                s_wstrb <= wstrb_o;
            end
            if (aw_seen && w_seen && !b_hold) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_awaddr[2:0]][8*b +: 8] <= s_wdata[8*b +: 8];
                bvalid_i <= 1'b1;
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
            end
            if (bvalid_i && bready_o) bvalid_i <= 1'b0;
            if (arvalid_o && arready_i) begin
                ar_seen  <= 1'b1;
                s_araddr <= araddr_o;
            end
            if (ar_seen) begin
                rvalid_i <= 1'b1;
                rdata_i  <= mem[s_araddr[2:0]];
                ar_seen  <= 1'b0;
            end
            if (rvalid_i && rready_o) rvalid_i <= 1'b0;
        end
    end

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got %b expected 00000", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o});
        end
        checks++;
        if ({done_o, err_o, rdata_o} !== 35'd0) begin
            errors++;
            $display("[TB] FAIL reset_status: done %b err %b rdata %h expected all zero", done_o, err_o, rdata_o);
        end
        checks++;
        if ({awaddr_o, araddr_o, wdata_o, wstrb_o, awid_o, arid_o} !== 108'd0) begin
            errors++;
            $display("[TB] FAIL reset_axi_regs: awaddr %h araddr %h wdata %h wstrb %h awid %h arid %h expected zero",
                     awaddr_o, araddr_o, wdata_o, wstrb_o, awid_o, arid_o);
        end
        areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int cycles = 0;
        int hs = 0;
        bit found = 0;
        @(negedge clk);
        addr_i[31:0]  = 32'd3;
        wdata_i[31:0] = 32'hDEADBEEF;
        wstrb_i[3:0]  = 4'hF;
        we_i[0]       = 1'b1;
        req_i         = 2'b01;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (awvalid_o && awready_i) begin
                hs++;
                checks++;
                if (awid_o !== 4'd0 || awaddr_o !== 32'd3 || wdata_o !== 32'hDEADBEEF || wstrb_o !== 4'hF) begin
                    errors++;
                    $display("[TB] FAIL wr_beat: awid %h awaddr %h wdata %h wstrb %h expected 0 3 deadbeef f",
                             awid_o, awaddr_o, wdata_o, wstrb_o);
                end
            end
            if (done_o !== 2'b00) found = 1;
        end
        req_i = 2'b00;
        checks++;
        if (cycles !== 4) begin
            errors++;
            $display("[TB] FAIL wr_latency: got %0d cycles expected 4", cycles);
        end
        checks++;
        if (done_o !== 2'b01 || err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr_done: done %b err %b expected 01 0", done_o, err_o);
        end
        checks++;
        if (hs !== 1) begin
            errors++;
            $display("[TB] FAIL wr_aw_count: got %0d handshakes expected 1", hs);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL wr_done_pulse: got %b expected 00", done_o);
        end
    endtask

    task automatic test_read_back();
        int cycles = 0;
        bit found = 0;
        bit addr_checked = 0;
        @(negedge clk);
        addr_i[63:32] = 32'd3;
        we_i[1]       = 1'b0;
        req_i         = 2'b10;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (arvalid_o && !addr_checked) begin
                addr_checked = 1;
                checks++;
                if (araddr_o !== 32'd3 || arid_o !== 4'd1) begin
                    errors++;
                    $display("[TB] FAIL rd_addr: araddr %h arid %h expected 3 1", araddr_o, arid_o);
                end
                addr_i[63:32] = 32'd7;
            end
            if (done_o !== 2'b00) found = 1;
        end
        req_i = 2'b00;
        checks++;
        if (!addr_checked || cycles !== 4) begin
            errors++;
            $display("[TB] FAIL rd_latency: got %0d cycles ar_seen %0d expected 4 1", cycles, addr_checked);
        end
        checks++;
        if (done_o !== 2'b10 || rdata_o !== 32'hDEADBEEF || err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_done: done %b rdata %h err %b expected 10 deadbeef 0", done_o, rdata_o, err_o);
        end
        checks++;
        if (araddr_o !== 32'd3) begin
            errors++;
            $display("[TB] FAIL rd_latched_addr: got %h expected 3", araddr_o);
        end
    endtask

    task automatic test_tie_fairness();
        logic [1:0] exp_done [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        int n = 0;
        int cyc = 0;
        int last_cyc = 0;
        int cnt0 = 0;
        int cnt1 = 0;
        @(negedge clk);
        addr_i  = {32'd3, 32'd3};
        we_i    = 2'b00;
        req_i   = 2'b11;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_o !== 2'b00) begin
                checks++;
                if (done_o !== exp_done[n] || arid_o !== {3'b000, exp_done[n][1]}) begin
                    errors++;
                    $display("[TB] FAIL tie_grant%0d: done %b arid %h expected %b", n, done_o, arid_o, exp_done[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 5) begin
                        errors++;
                        $display("[TB] FAIL tie_gap%0d: got %0d cycles expected 5", n, cyc - last_cyc);
                    end
                end
                cnt0 += int'(done_o[0]);
                cnt1 += int'(done_o[1]);
                last_cyc = cyc;
                n++;
            end
        end
        req_i = 2'b00;
        repeat (6) begin
            @(negedge clk);
            cnt0 += int'(done_o[0]);
            cnt1 += int'(done_o[1]);
        end
        checks++;
        if (cnt0 !== 2 || cnt1 !== 2) begin
            errors++;
            $display("[TB] FAIL tie_counts: req0 %0d req1 %0d expected 2 2", cnt0, cnt1);
        end
    endtask

    task automatic test_backpressure();
        bit found = 0;
        @(negedge clk);
        awready_i     = 1'b0;
        wready_i      = 1'b1;
        bresp_i       = 2'b10;
        addr_i[31:0]  = 32'd5;
        wdata_i[31:0] = 32'h12345678;
        wstrb_i[3:0]  = 4'hF;
        we_i[0]       = 1'b1;
        req_i         = 2'b01;
        @(negedge clk);
        checks++;
        if (awvalid_o !== 1'b1 || wvalid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_valids: aw %b w %b expected 1 1", awvalid_o, wvalid_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wvalid_o !== 1'b0 || awvalid_o !== 1'b1 || awaddr_o !== 32'd5) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d: w %b aw %b awaddr %h expected 0 1 5", i, wvalid_o, awvalid_o, awaddr_o);
            end
        end
        awready_i = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done_o !== 2'b00) found = 1;
        end
        req_i = 2'b00;
        checks++;
        if (done_o !== 2'b01 || err_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_done: done %b err %b expected 01 1", done_o, err_o);
        end
        bresp_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wresp();
        bit found = 0;
        int dones = 0;
        @(negedge clk);
        b_hold        = 1'b1;
        addr_i[31:0]  = 32'd2;
        wdata_i[31:0] = 32'hA5A5A5A5;
        we_i[0]       = 1'b1;
        req_i         = 2'b01;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bready_o === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL rst_reach_wresp: bready %b expected 1", bready_o);
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_o} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL rst_async: aw %b w %b b %b ar %b r %b done %b expected all 0",
                     awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_o);
        end
        req_i  = 2'b00;
        b_hold = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_o !== 2'b00) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL rst_no_done: got %0d pulses expected 0", dones);
        end
        addr_i = {32'd5, 32'd3};
        we_i   = 2'b00;
        req_i  = 2'b11;
        found  = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done_o !== 2'b00) found = 1;
        end
        req_i = 2'b00;
        checks++;
        if (done_o !== 2'b01 || arid_o !== 4'd0 || rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL rst_regrant: done %b arid %h rdata %h expected 01 0 deadbeef", done_o, arid_o, rdata_o);
        end
        @(negedge clk);
    endtask

`ifdef AXI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int high = 0;
        bit found = 0;
        @(negedge clk);
        arready_i    = 1'b0;
        addr_i[31:0] = 32'd3;
        we_i[0]      = 1'b0;
        req_i        = 2'b01;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (arvalid_o) high++;
            if (done_o !== 2'b00) found = 1;
        end
        req_i = 2'b00;
        checks++;
        if (high !== 16) begin
            errors++;
            $display("[TB] FAIL tmo_len: arvalid high %0d cycles expected 16", high);
        end
        checks++;
        if (done_o !== 2'b01 || err_o !== 1'b1 || rdata_o !== 32'd0 || arvalid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_done: done %b err %b rdata %h arvalid %b expected 01 1 0 0",
                     done_o, err_o, rdata_o, arvalid_o);
        end
        arready_i = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        areset    = 1'b1;
        req_i     = '0;
        we_i      = '0;
        addr_i    = '0;
        wdata_i   = '0;
        wstrb_i   = '0;
        awready_i = 1'b1;
        wready_i  = 1'b1;
        arready_i = 1'b1;
        bresp_i   = 2'b00;
        b_hold    = 1'b0;
        $display("[TB] starting axi_reg_arbiter bench");
        test_reset();
        test_single_write();
        test_read_back();
        test_tie_fairness();
        test_backpressure();
        test_reset_mid_wresp();
`ifdef AXI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
